// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizes for the SDRAM arbiter slice.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF          = 24;
  localparam int DATA_W_DEF          = 32;
  localparam int MAX_OUTSTANDING_DEF = 8;
  localparam int STARVE_LIMIT_DEF    = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_SIM  = 2'd2
  } owner_t;

  typedef enum logic {
    TAG_VGA = 1'b0,
    TAG_SIM = 1'b1
  } tag_t;

endpackage

// File: rtl/sdram_tag_fifo.sv
// In-order FIFO of requester tags for outstanding SDRAM reads.
module sdram_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUTSTANDING_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output tag_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  tag_t             store [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A pop frees the head slot in the same cycle, so a push is allowed when full if popping.
  always_comb begin
    full    = (count == FULL_COUNT);
    empty   = (count == '0);
    do_pop  = pop & ~empty;
    do_push = push & (~full | pop);
    head    = store[rd_ptr];
  end

  // Pointer and occupancy state, flushed by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag storage; contents are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (do_push) store[wr_ptr] <= push_tag;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester arbiter (VGA scanout, sim engine) for one pipelined Avalon-MM SDRAM port.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int STARVE_LIMIT    = STARVE_LIMIT_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   vga_address,
  input  logic                vga_read,
  output logic                vga_waitrequest,
  output logic [DATA_W-1:0]   vga_readdata,
  output logic                vga_readdatavalid,
  input  logic [ADDR_W-1:0]   sim_address,
  input  logic                sim_read,
  input  logic                sim_write,
  input  logic [DATA_W-1:0]   sim_writedata,
  input  logic [DATA_W/8-1:0] sim_byteenable,
  output logic                sim_waitrequest,
  output logic [DATA_W-1:0]   sim_readdata,
  output logic                sim_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic                mem_waitrequest,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                mem_readdatavalid,
  output logic                resp_error
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  owner_t           lock;
  owner_t           lock_next;
  owner_t           winner;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_next;
  logic             sim_req;
  logic             vga_elig;
  logic             sim_elig;
  logic             starved;
  logic             accepted;
  logic             push_read;
  logic             resp_valid;
  logic             fifo_full;
  logic             fifo_empty;
  tag_t             fifo_head;
  tag_t             push_tag;

  // Winner selection and zero-latency command mux; a read is only eligible with a free tag slot.
  always_comb begin
    sim_req  = sim_read | sim_write;
    vga_elig = vga_read & ~fifo_full;
    sim_elig = sim_write | (sim_read & ~fifo_full);
    starved  = (starve_cnt == CNT_MAX);

    winner = OWN_NONE;
    if (reset) begin
      winner = OWN_NONE;
    end else if (lock == OWN_VGA) begin
      winner = vga_elig ? OWN_VGA : OWN_NONE;
    end else if (lock == OWN_SIM) begin
      winner = sim_elig ? OWN_SIM : OWN_NONE;
    end else if (vga_elig && !(starved && sim_elig)) begin
      winner = OWN_VGA;
    end else if (sim_elig) begin
      winner = OWN_SIM;
    end else begin
      winner = OWN_NONE;
    end

    mem_address     = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_writedata   = '0;
    mem_byteenable  = '0;
    vga_waitrequest = 1'b1;
    sim_waitrequest = 1'b1;
    case (winner)
      OWN_VGA: begin
        mem_address     = vga_address;
        mem_read        = 1'b1;
        mem_byteenable  = '1;
        vga_waitrequest = mem_waitrequest;
      end
      OWN_SIM: begin
        mem_address     = sim_address;
        mem_read        = sim_read;
        mem_write       = sim_write;
        mem_writedata   = sim_writedata;
        mem_byteenable  = sim_byteenable;
        sim_waitrequest = mem_waitrequest;
      end
      default: begin
        mem_read = 1'b0;
      end
    endcase

    accepted  = (mem_read | mem_write) & ~mem_waitrequest;
    push_read = mem_read & ~mem_waitrequest;
    push_tag  = (winner == OWN_VGA) ? TAG_VGA : TAG_SIM;
  end

  // Lock and starvation next-state.
  always_comb begin
    lock_next = OWN_NONE;
    if (winner != OWN_NONE && mem_waitrequest) begin
      lock_next = winner;
    end else begin
      lock_next = OWN_NONE;
    end

    starve_next = starve_cnt;
    if (!sim_req || (accepted && winner == OWN_SIM)) begin
      starve_next = '0;
    end else if (accepted && winner == OWN_VGA && starve_cnt != CNT_MAX) begin
      starve_next = starve_cnt + CNT_W'(1);
    end else begin
      starve_next = starve_cnt;
    end
  end

  // Lock, starvation counter and sticky error registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock       <= OWN_NONE;
      starve_cnt <= '0;
      resp_error <= 1'b0;
    end else begin
      lock       <= lock_next;
      starve_cnt <= starve_next;
      if (mem_readdatavalid && fifo_empty) resp_error <= 1'b1;
    end
  end

  // Response steering by the head tag; beats with no outstanding read are dropped.
  always_comb begin
    resp_valid        = mem_readdatavalid & ~fifo_empty & ~reset;
    vga_readdatavalid = resp_valid & (fifo_head == TAG_VGA);
    sim_readdatavalid = resp_valid & (fifo_head == TAG_SIM);
    vga_readdata      = reset ? '0 : mem_readdata;
    sim_readdata      = reset ? '0 : mem_readdata;
  end

  sdram_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_read),
    .push_tag (push_tag),
    .pop      (mem_readdatavalid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed testbench for sdram_arbiter with a simple fixed-latency SDRAM responder.
module tb_sdram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] vga_address;
  logic        vga_read;
  logic        vga_waitrequest;
  logic [31:0] vga_readdata;
  logic        vga_readdatavalid;
  logic [23:0] sim_address;
  logic        sim_read;
  logic        sim_write;
  logic [31:0] sim_writedata;
  logic [3:0]  sim_byteenable;
  logic        sim_waitrequest;
  logic [31:0] sim_readdata;
  logic        sim_readdatavalid;
  logic [23:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic        resp_error;

  logic        auto_resp;
  logic        man_rdv;
  logic [31:0] man_data;
  logic [2:0]  pv;
  logic [31:0] pd [3];

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] vga_got [$];
  logic [31:0] sim_got [$];

  always #5 clock = ~clock;

  sdram_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .vga_address       (vga_address),
    .vga_read          (vga_read),
    .vga_waitrequest   (vga_waitrequest),
    .vga_readdata      (vga_readdata),
    .vga_readdatavalid (vga_readdatavalid),
    .sim_address       (sim_address),
    .sim_read          (sim_read),
    .sim_write         (sim_write),
    .sim_writedata     (sim_writedata),
    .sim_byteenable    (sim_byteenable),
    .sim_waitrequest   (sim_waitrequest),
    .sim_readdata      (sim_readdata),
    .sim_readdatavalid (sim_readdatavalid),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_byteenable    (mem_byteenable),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .resp_error        (resp_error)
  );

  // Responder: each accepted read returns {A5, address} a few cycles later.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pv    <= 3'b000;
      pd[0] <= 32'h0;
      pd[1] <= 32'h0;
      pd[2] <= 32'h0;
    end else begin
      pv    <= {pv[1:0], mem_read & ~mem_waitrequest & auto_resp};
      pd[0] <= {8'hA5, mem_address};
      pd[1] <= pd[0];
      pd[2] <= pd[1];
    end
  end

  assign mem_readdatavalid = auto_resp ? pv[2] : man_rdv;
  assign mem_readdata      = auto_resp ? pd[2] : man_data;

  always @(negedge clock) begin
    if (vga_readdatavalid) vga_got.push_back(vga_readdata);
    if (sim_readdatavalid) sim_got.push_back(sim_readdata);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; vga_address = 24'h0; vga_read = 1'b0;
    sim_address = 24'h0; sim_read = 1'b0; sim_write = 1'b0;
    sim_writedata = 32'h0; sim_byteenable = 4'h0; mem_waitrequest = 1'b0;
    auto_resp = 1'b1; man_rdv = 1'b0; man_data = 32'h0;
    #2;
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_vga_wait", vga_waitrequest, 1'b1);
    chk("rst_sim_wait", sim_waitrequest, 1'b1);
    chk("rst_resp_error", resp_error, 1'b0);
    idle(2);
    reset = 1'b0;
    step();

    // VGA-only burst
    for (int i = 0; i < 8; i++) begin
      vga_read = 1'b1; vga_address = 24'(i);
      #2;
      chk("burst_mem_read", mem_read, 1'b1);
      chk("burst_mem_addr", mem_address, 24'(i));
      chk("burst_vga_wait", vga_waitrequest, 1'b0);
      step();
    end
    vga_read = 1'b0;
    idle(6);
    chk("burst_vga_beats", vga_got.size(), 8);
    chk("burst_sim_beats", sim_got.size(), 0);
    for (int i = 0; i < 8; i++)
      if (i < vga_got.size()) chk("burst_vga_data", vga_got[i], {8'hA5, 24'(i)});
    vga_got.delete(); sim_got.delete();

    // Contention: 16 VGA grants then one sim grant
    vga_read = 1'b1; vga_address = 24'h000400;
    sim_read = 1'b1; sim_address = 24'h000500;
    for (int c = 0; c < 34; c++) begin
      #2;
      chk("cont_vga_wait", vga_waitrequest, (c % 17 == 16) ? 1'b1 : 1'b0);
      chk("cont_sim_wait", sim_waitrequest, (c % 17 == 16) ? 1'b0 : 1'b1);
      chk("cont_mem_addr", mem_address, (c % 17 == 16) ? 24'h000500 : 24'h000400);
      step();
    end
    vga_read = 1'b0; sim_read = 1'b0;
    idle(6);
    chk("cont_vga_beats", vga_got.size(), 32);
    chk("cont_sim_beats", sim_got.size(), 2);
    vga_got.delete(); sim_got.delete();

    // Waitrequest lock holds sim until accepted
    mem_waitrequest = 1'b1; sim_read = 1'b1; sim_address = 24'h000200;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin vga_read = 1'b1; vga_address = 24'h000300; end
      #2;
      chk("lock_mem_addr", mem_address, 24'h000200);
      chk("lock_sim_wait", sim_waitrequest, 1'b1);
      chk("lock_vga_wait", vga_waitrequest, 1'b1);
      step();
    end
    mem_waitrequest = 1'b0;
    #2;
    chk("lock_acc_addr", mem_address, 24'h000200);
    chk("lock_acc_sim_wait", sim_waitrequest, 1'b0);
    chk("lock_acc_vga_wait", vga_waitrequest, 1'b1);
    step();
    sim_read = 1'b0;
    #2;
    chk("lock_vga_addr", mem_address, 24'h000300);
    chk("lock_vga_wait2", vga_waitrequest, 1'b0);
    step();
    vga_read = 1'b0;
    idle(6);
    chk("lock_vga_beats", vga_got.size(), 1);
    chk("lock_sim_beats", sim_got.size(), 1);
    vga_got.delete(); sim_got.delete();

    // FIFO full: reads blocked, writes pass
    auto_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vga_read = 1'b1; vga_address = 24'h000010 + 24'(i);
      #2;
      chk("full_fill_read", mem_read, 1'b1);
      step();
    end
    vga_address = 24'h000018;
    sim_write = 1'b1; sim_address = 24'h000100;
    sim_writedata = 32'hDEADBEEF; sim_byteenable = 4'hF;
    #2;
    chk("full_mem_read", mem_read, 1'b0);
    chk("full_mem_write", mem_write, 1'b1);
    chk("full_wr_addr", mem_address, 24'h000100);
    chk("full_wr_data", mem_writedata, 32'hDEADBEEF);
    chk("full_wr_be", mem_byteenable, 4'hF);
    chk("full_sim_wait", sim_waitrequest, 1'b0);
    chk("full_vga_wait", vga_waitrequest, 1'b1);
    step();
    sim_write = 1'b0; man_rdv = 1'b1; man_data = 32'h00000055;
    #2;
    chk("full_pop_valid", vga_readdatavalid, 1'b1);
    chk("full_pop_data", vga_readdata, 32'h00000055);
    chk("full_still_blocked", mem_read, 1'b0);
    step();
    man_rdv = 1'b0;
    #2;
    chk("full_freed_read", mem_read, 1'b1);
    chk("full_freed_addr", mem_address, 24'h000018);
    chk("full_freed_wait", vga_waitrequest, 1'b0);
    step();
    vga_read = 1'b0;
    for (int i = 0; i < 8; i++) begin
      man_rdv = 1'b1; man_data = 32'h00000100 + 32'(i);
      #2;
      chk("full_drain_valid", vga_readdatavalid, 1'b1);
      step();
    end
    man_rdv = 1'b0;
    step();

    // Interleaved tags V,S,V,S
    vga_read = 1'b1; vga_address = 24'h000020; step();
    vga_read = 1'b0; sim_read = 1'b1; sim_address = 24'h000021; step();
    sim_read = 1'b0; vga_read = 1'b1; vga_address = 24'h000022; step();
    vga_read = 1'b0; sim_read = 1'b1; sim_address = 24'h000023; step();
    sim_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      man_rdv = 1'b1; man_data = 32'h11 * 32'(i + 1);
      #2;
      chk("il_vga_valid", vga_readdatavalid, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("il_sim_valid", sim_readdatavalid, (i % 2 == 1) ? 1'b1 : 1'b0);
      if (i % 2 == 0) chk("il_vga_data", vga_readdata, 32'h11 * 32'(i + 1));
      else            chk("il_sim_data", sim_readdata, 32'h11 * 32'(i + 1));
      step();
    end
    man_rdv = 1'b0;
    step();
    chk("il_no_error", resp_error, 1'b0);

    // Spurious response with empty FIFO
    man_rdv = 1'b1; man_data = 32'h00000099;
    #2;
    chk("spur_vga_valid", vga_readdatavalid, 1'b0);
    chk("spur_sim_valid", sim_readdatavalid, 1'b0);
    step();
    man_rdv = 1'b0;
    #2;
    chk("spur_err_set", resp_error, 1'b1);
    idle(3);
    chk("spur_err_held", resp_error, 1'b1);

    // Async reset mid-burst
    auto_resp = 1'b1; vga_read = 1'b1; vga_address = 24'h000600;
    sim_write = 1'b1; sim_address = 24'h000700;
    idle(3);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_read", mem_read, 1'b0);
    chk("mid_rst_mem_write", mem_write, 1'b0);
    chk("mid_rst_mem_addr", mem_address, 24'h0);
    chk("mid_rst_vga_wait", vga_waitrequest, 1'b1);
    chk("mid_rst_sim_wait", sim_waitrequest, 1'b1);
    chk("mid_rst_vga_valid", vga_readdatavalid, 1'b0);
    chk("mid_rst_sim_valid", sim_readdatavalid, 1'b0);
    chk("mid_rst_error", resp_error, 1'b0);
    vga_read = 1'b0; sim_write = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(5);
    chk("post_rst_error", resp_error, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single Avalon-MM pipelined SDRAM master port between two requesters.
  - VGA scanout fetch: read-only, real-time, high priority.
  - Sand-simulation engine: read/write, best-effort.
- Tracks outstanding reads in order and routes each returning readdata beat to the requester that issued it.
- Sits between vga_render / sim engine and the SDRAM controller slave.

Parameters:
- ADDR_W, 24, word address width on all ports.
- DATA_W, 32, data width on all ports.
- MAX_OUTSTANDING, 8, depth of the read tag FIFO; power of two, ≥2.
- STARVE_LIMIT, 16, consecutive VGA-won arbitrations while sim waits before sim is forced one grant.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- vga_address  in  ADDR_W  VGA read address.
- vga_read  in  1  VGA read request.
- vga_waitrequest  out  1  VGA command not accepted this cycle.
- vga_readdata  out  DATA_W  VGA read data.
- vga_readdatavalid  out  1  vga_readdata valid.
- sim_address  in  ADDR_W  sim address.
- sim_read  in  1  sim read request.
- sim_write  in  1  sim write request; never asserted together with sim_read.
- sim_writedata  in  DATA_W  sim write data.
- sim_byteenable  in  DATA_W/8  sim byte enables.
- sim_waitrequest  out  1  sim command not accepted.
- sim_readdata  out  DATA_W  sim read data.
- sim_readdatavalid  out  1  sim_readdata valid.
- mem_address  out  ADDR_W  to SDRAM slave.
- mem_read  out  1  to SDRAM slave.
- mem_write  out  1  to SDRAM slave.
- mem_writedata  out  DATA_W  to SDRAM slave.
- mem_byteenable  out  DATA_W/8  to SDRAM slave.
- mem_waitrequest  in  1  from SDRAM slave.
- mem_readdata  in  DATA_W  from SDRAM slave.
- mem_readdatavalid  in  1  from SDRAM slave.
- resp_error  out  1  sticky: readdatavalid arrived with tag FIFO empty.

Behaviour:
- Reset (async, active-high): grant lock = NONE, starvation counter = 0, tag FIFO empty, resp_error = 0.
  - mem_read = mem_write = 0; both *_waitrequest = 1; both *_readdatavalid = 0.
  - Data/address outputs are don't-care and driven 0.
- Command acceptance: at posedge, when (mem_read | mem_write) & !mem_waitrequest.
- Arbitration is combinational from current requests, lock state and counter.
  - Command path is zero-latency: the winner's address/data/enables are muxed straight to mem_*.
- Lock states: NONE, VGA, SIM.
  - Owner presents a command and mem_waitrequest=1 → lock = owner; the mux holds the owner until acceptance, then returns to NONE.
  - Requesters hold their commands stable while their waitrequest is high.
- Winner selection when lock = NONE:
  - VGA if vga_read, unless starvation counter == STARVE_LIMIT and sim is requesting; then sim wins.
  - Otherwise sim if it is requesting.
- Starvation counter:
  - Increments on each accepted VGA command while sim is requesting; saturates at STARVE_LIMIT.
  - Clears on any accepted sim command or when sim is not requesting.
- Read eligibility: a read is presented only if the tag FIFO is not full.
  - FIFO full and winner is a read → mem_read = 0 and the requester's waitrequest = 1.
  - Writes may still be presented; sim write is eligible while FIFO is full. VGA (read-only) just waits, and sim may win meanwhile.
- Loser: *_waitrequest = 1 whenever not granted or not accepted. Winner: waitrequest = mem_waitrequest.
- Tag FIFO: push requester id on every accepted read; pop on mem_readdatavalid.
  - Simultaneous push and pop is legal at any occupancy, including full (count unchanged) and empty (pass-through not required; push lands, pop of empty counts as error).
- Response routing: vga_readdata = sim_readdata = mem_readdata, unregistered.
  - vga_readdatavalid = mem_readdatavalid & head==VGA; sim analogous.
  - Same-cycle as mem_readdatavalid, zero latency; order preserved.
- Empty-FIFO response: readdatavalid with FIFO empty → beat dropped (neither valid asserted), resp_error set until reset.
- Writes produce no response and push no tag.
- Reset mid-operation: FIFO flushed; in-flight SDRAM responses arriving afterwards are dropped and set resp_error. The SDRAM controller shares this reset, so none are expected.

Decomposition:
- Package sdram_arb_pkg:
  - typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_SIM} owner_t.
  - typedef enum logic {TAG_VGA, TAG_SIM} tag_t.
  - Default width constants.
- One sub-module: sdram_tag_fifo.
  - Synchronous FIFO of tag_t, MAX_OUTSTANDING deep.
  - Outputs full/empty/head; supports simultaneous push/pop; async-reset flush.

Test Plan:
- VGA-only burst: vga_read at addresses 0x000000..0x000007, mem_waitrequest=0, readdata returned 3 cycles later → 8 vga_readdatavalid beats in order; sim_readdatavalid never high.
- Contention: both read every cycle with STARVE_LIMIT=16 → exactly 16 VGA acceptances then 1 sim acceptance, repeating; sim_waitrequest high otherwise.
- Waitrequest lock: sim read presented with mem_waitrequest=1 for 4 cycles, vga_read rises at cycle 1 → mem_address stays the sim address until sim is accepted, then VGA is granted.
- FIFO full: 8 accepted reads, no responses → 9th read held (mem_read=0); sim write of 0xDEADBEEF at 0x000100 still accepted; first response frees a slot and the read issues next cycle.
- Interleaved tags: issue V,S,V,S reads; return 4 beats 0x11,0x22,0x33,0x44 → vga gets 0x11,0x33; sim gets 0x22,0x44.
- Spurious response: mem_readdatavalid with empty FIFO → no valid out, resp_error=1 and held; async reset mid-burst → all outputs at reset values immediately, resp_error=0.
